simon_iter_core: RTL and testbench
==================================

Name: simon_iter_core

Overview:
Parametrised iterative SIMON block cipher core that replaces the discrete key-expander/round pairing with a single block.
- On key load, it expands the key into an internal round-key store.
- It then encrypts or decrypts blocks one round per clock, with reversed key order for decryption.
- It sits between the host-side register interface and the crypto datapath, using valid/ready handshakes on all three channels.

Parameters:
WORD_W, 32, word size n in bits (block = 2*WORD_W); legal values 16, 24, 32, 48, 64
KEY_WORDS, 4, key words m; legal values 2, 3, 4
ROUNDS, 44, round count T
Z_SEQ, 3, constant sequence index (0..4) selecting z0..z4

Ports:
ck  in  1  clock, rising edge
nrst  in  1  reset, synchronous, active-low
key  in  KEY_WORDS*WORD_W  key; k[0] = key[WORD_W-1:0], k[i] = word i
key_valid  in  1  key offered
key_ready  out  1  key can be accepted
blk_in  in  2*WORD_W  input block; x = upper word, y = lower word
enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled with blk_in
in_valid  in  1  block offered
in_ready  out  1  block can be accepted
blk_out  out  2*WORD_W  result block, same {x,y} packing
out_valid  out  1  result available
out_ready  in  1  result consumed
key_loaded  out  1  round-key store valid

Behaviour:
- Reset (nrst low at an edge): state=NOKEY; key_ready=1, in_ready=0, out_valid=0, key_loaded=0, blk_out=0. The key store is not cleared but is marked invalid. Reset wins over every other event, including mid-expansion or mid-run; any in-flight result is discarded.
- FSM states: NOKEY, KEXP, IDLE, RUN, HOLD.
- NOKEY: key_ready=1.
  - key_valid&key_ready -> copy k[0..m-1] into store[0..m-1], round counter i=m, enter KEXP.
  - in_valid is ignored (in_ready=0).
- KEXP: one store word per cycle, store[i] = c ^ store[i-m] ^ tmp ^ z[Z_SEQ][(i-m) mod 62], with c = 2^WORD_W - 4.
  - m=2: tmp = R3(store[i-1]); tmp ^= R1(tmp).
  - m=3: same as m=2.
  - m=4: tmp = R3(store[i-1]) ^ store[i-3]; tmp ^= R1(tmp).
  - Rr = rotate right by r within WORD_W bits.
  - After ROUNDS-m cycles: key_loaded=1, enter IDLE.
  - key_ready=0 and in_ready=0 throughout.
- IDLE: key_ready=1, in_ready=1.
  - in_valid -> latch x, y and mode; round index r=0; enter RUN.
  - key_valid (with in_valid low) -> key_loaded=0, enter KEXP.
  - Both valid in the same cycle -> block accepted, key ignored (key_ready drops to 0 at the next edge).
- RUN: one round per edge for ROUNDS edges; key_ready=0, in_ready=0.
  - f(x) = (L1 x & L8 x) ^ L2 x, where Lr = rotate left.
  - Encrypt: (x,y) <- (y ^ f(x) ^ store[r], x).
  - Decrypt: (x,y) <- (y, x ^ f(y) ^ store[ROUNDS-1-r]).
  - After the final round: blk_out={x,y}, out_valid=1, enter HOLD.
  - Latency: accept edge E0, rounds at E1..E_ROUNDS; out_valid is high after E_ROUNDS. Throughput is one block per ROUNDS+1 cycles, plus any HOLD time.
- HOLD: out_valid and blk_out stay stable until out_ready.
  - out_valid&out_ready -> out_valid=0, enter IDLE. in_ready=0 during HOLD, so no overlap.
  - Next block can be accepted the cycle after the handshake.
- All arithmetic is bitwise, modulo WORD_W; no carries.
- z sequences are 62-bit standard constants held as localparams; the index wraps mod 62.
- ROUNDS > 62*... is not supported; require KEY_WORDS < ROUNDS <= 72. Elaboration error otherwise.

Test Plan:
- Defaults (Simon64/128): key=0x1b1a1918_13121110_0b0a0908_03020100, blk_in=0x656b696c_20646e75, enc_dec=1 -> out_valid exactly 44 edges after accept, blk_out=0x44c8fc20_b9dfa07a. key_loaded rises exactly 40 cycles after key accept.
- Same key, blk_in=0x44c8fc20_b9dfa07a, enc_dec=0 -> blk_out=0x656b696c_20646e75.
- WORD_W=16, KEY_WORDS=4, ROUNDS=32, Z_SEQ=0: key=0x1918_1110_0908_0100, pt=0x6565_6877 -> ct=0xc69b_e9bb; decrypt returns 0x65656877.
- Backpressure: hold out_ready=0 for 20 cycles -> blk_out stable, in_ready=0, key_ready=0. out_ready=1 -> out_valid low next edge, in_ready high.
- Reset mid-operation: nrst=0 at RUN round 10 -> next edge out_valid=0, key_loaded=0, in_ready=0, key_ready=1. Block offered afterwards is not accepted until a new key is expanded.
- Rekey in IDLE: load the all-zero key, then the test key. Encrypting 0x656b696c_20646e75 gives the reference ciphertext, proving the store was fully rewritten. Key and block both valid in IDLE -> block accepted, key_ready=0.

Source files
------------

// File: rtl/simon_iter_core.sv
// Iterative SIMON block cipher core: expands a key into an internal round-key
// store, then encrypts or decrypts one block at a time, one round per clock.
module simon_iter_core #(
    parameter int WORD_W    = 32,
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = 44,
    parameter int Z_SEQ     = 3
) (
    input  logic                          ck,
    input  logic                          nrst,
    input  logic [KEY_WORDS*WORD_W-1:0]   key,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [2*WORD_W-1:0]           blk_in,
    input  logic                          enc_dec,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [2*WORD_W-1:0]           blk_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          key_loaded
);

    if (!(WORD_W == 16 || WORD_W == 24 || WORD_W == 32 || WORD_W == 48 || WORD_W == 64)) begin : g_bad_word
        $error("simon_iter_core: WORD_W must be 16, 24, 32, 48 or 64");
    end
    if (KEY_WORDS < 2 || KEY_WORDS > 4) begin : g_bad_key
        $error("simon_iter_core: KEY_WORDS must be 2, 3 or 4");
    end
    if (ROUNDS <= KEY_WORDS || ROUNDS > 72) begin : g_bad_rounds
        $error("simon_iter_core: require KEY_WORDS < ROUNDS <= 72");
    end
    if (Z_SEQ < 0 || Z_SEQ > 4) begin : g_bad_z
        $error("simon_iter_core: Z_SEQ must be 0..4");
    end

    localparam int IDX_W = $clog2(ROUNDS);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0]  M_IDX = IDX_W'(KEY_WORDS);
    localparam logic [WORD_W-1:0] C     = ~WORD_W'(3);

    // z sequences stored bit-reversed so that bit j is the j-th sequence element.
    localparam logic [61:0] Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
    localparam logic [61:0] Z1 = 62'b01011010000110010011111011100010101101000011001001111101110001;
    localparam logic [61:0] Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;
    localparam logic [61:0] Z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;
    localparam logic [61:0] Z4 = 62'b11110111001001010011000011101000000100011011010110011110001011;
    localparam logic [61:0] Z_SEL = (Z_SEQ == 0) ? Z0 :
                                    (Z_SEQ == 1) ? Z1 :
                                    (Z_SEQ == 2) ? Z2 :
                                    (Z_SEQ == 3) ? Z3 : Z4;

    typedef enum logic [2:0] {NOKEY, KEXP, IDLE, RUN, HOLD} state_e;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int r);
        return (v << r) | (v >> (WORD_W - r));
    endfunction

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int r);
        return (v >> r) | (v << (WORD_W - r));
    endfunction

    function automatic logic [WORD_W-1:0] f_fn(input logic [WORD_W-1:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ctr_q, ctr_d;
    logic [5:0]          zi_q, zi_d;
    logic [WORD_W-1:0]   x_q, x_d;
    logic [WORD_W-1:0]   y_q, y_d;
    logic                mode_q, mode_d;
    logic                key_loaded_q, key_loaded_d;
    logic [WORD_W-1:0]   store_q [ROUNDS];

    logic                key_load;
    logic                kexp_we;
    logic [WORD_W-1:0]   kexp_tmp;
    logic [WORD_W-1:0]   kexp_word;
    logic [WORD_W-1:0]   rk;

    always_comb begin
        kexp_tmp = rotr(store_q[ctr_q - IDX_W'(1)], 3);
        if (KEY_WORDS == 4) begin
            kexp_tmp = kexp_tmp ^ store_q[ctr_q - IDX_W'(3)];
        end
        kexp_tmp  = kexp_tmp ^ rotr(kexp_tmp, 1);
        kexp_word = C ^ store_q[ctr_q - M_IDX] ^ kexp_tmp ^ WORD_W'(Z_SEL[zi_q]);
    end

    // Decryption walks the round keys from the top of the store downwards.
    assign rk = store_q[mode_q ? ctr_q : (LAST - ctr_q)];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        ctr_d        = ctr_q;
        zi_d         = zi_q;
        x_d          = x_q;
        y_d          = y_q;
        mode_d       = mode_q;
        key_loaded_d = key_loaded_q;
        key_load     = 1'b0;
        kexp_we      = 1'b0;

        unique case (state_q)
            NOKEY: begin
                if (key_valid) begin
                    key_load = 1'b1;
                    ctr_d    = M_IDX;
                    zi_d     = '0;
                    state_d  = KEXP;
                end
            end
            KEXP: begin
                kexp_we = 1'b1;
                zi_d    = (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
                if (ctr_q == LAST) begin
                    key_loaded_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    ctr_d = ctr_q + IDX_W'(1);
                end
            end
            IDLE: begin
                // A block offered alongside a key takes priority; the key is ignored.
                if (in_valid) begin
                    x_d     = blk_in[2*WORD_W-1:WORD_W];
                    y_d     = blk_in[WORD_W-1:0];
                    mode_d  = enc_dec;
                    ctr_d   = '0;
                    state_d = RUN;
                end else if (key_valid) begin
                    key_load     = 1'b1;
                    key_loaded_d = 1'b0;
                    ctr_d        = M_IDX;
                    zi_d         = '0;
                    state_d      = KEXP;
                end
            end
            RUN: begin
                if (mode_q) begin
                    x_d = y_q ^ f_fn(x_q) ^ rk;
                    y_d = x_q;
                end else begin
                    x_d = y_q;
                    y_d = x_q ^ f_fn(y_q) ^ rk;
                end
                if (ctr_q == LAST) begin
                    state_d = HOLD;
                end else begin
                    ctr_d = ctr_q + IDX_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = NOKEY;
        endcase
    end

    always_ff @(posedge ck) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!nrst) begin
            state_q      <= NOKEY;
            ctr_q        <= '0;
            zi_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            mode_q       <= 1'b0;
            key_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            zi_q         <= zi_d;
            x_q          <= x_d;
            y_q          <= y_d;
            mode_q       <= mode_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    // NOTE: the round-key store has no reset; key_loaded marks whether its contents are valid.
    always_ff @(posedge ck) begin
        if (key_load) begin
            for (int j = 0; j < KEY_WORDS; j++) begin
                store_q[j] <= key[j*WORD_W +: WORD_W];
            end
        end else if (kexp_we) begin
            store_q[ctr_q] <= kexp_word;
        end
    end

    assign key_ready  = (state_q == NOKEY) || (state_q == IDLE);
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == HOLD);
    assign blk_out    = {x_q, y_q};
    assign key_loaded = key_loaded_q;

endmodule

// File: tb/tb_simon_iter_core.sv
// Self-checking bench for simon_iter_core: Simon64/128 and Simon32/64 instances,
// with expected results queued at stimulus time and compared on output handshake.
module tb_simon_iter_core;

    localparam logic [127:0] KEY   = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  PT    = 64'h656b696c_20646e75;
    localparam logic [63:0]  CT    = 64'h44c8fc20_b9dfa07a;
    localparam logic [63:0]  B_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0]  B_PT  = 32'h6565_6877;
    localparam logic [31:0]  B_CT  = 32'hc69b_e9bb;

    logic ck = 1'b0;
    logic nrst = 1'b0;
    always #5 ck = ~ck;

    logic [127:0] a_key = '0;
    logic         a_key_valid = 1'b0, a_key_ready;
    logic [63:0]  a_blk_in = '0, a_blk_out;
    logic         a_enc_dec = 1'b1, a_in_valid = 1'b0, a_in_ready;
    logic         a_out_valid, a_out_ready = 1'b1, a_key_loaded;

    logic [63:0]  b_key = '0;
    logic         b_key_valid = 1'b0, b_key_ready;
    logic [31:0]  b_blk_in = '0, b_blk_out;
    logic         b_enc_dec = 1'b1, b_in_valid = 1'b0, b_in_ready;
    logic         b_out_valid, b_out_ready = 1'b1, b_key_loaded;

    simon_iter_core dut_a (
        .ck(ck), .nrst(nrst),
        .key(a_key), .key_valid(a_key_valid), .key_ready(a_key_ready),
        .blk_in(a_blk_in), .enc_dec(a_enc_dec), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .blk_out(a_blk_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .key_loaded(a_key_loaded)
    );

    simon_iter_core #(.WORD_W(16), .KEY_WORDS(4), .ROUNDS(32), .Z_SEQ(0)) dut_b (
        .ck(ck), .nrst(nrst),
        .key(b_key), .key_valid(b_key_valid), .key_ready(b_key_ready),
        .blk_in(b_blk_in), .enc_dec(b_enc_dec), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .blk_out(b_blk_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .key_loaded(b_key_loaded)
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] a_exp_q[$];
    logic [31:0] b_exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboards: compare on the negedge before the output handshake edge.
    always @(negedge ck) begin
        if (nrst && a_out_valid && a_out_ready) begin
            if (a_exp_q.size() == 0) check("a_unexpected_out", 64'(a_exp_q.size()), 64'd1);
            else check("a_blk_out", a_blk_out, a_exp_q.pop_front());
        end
        if (nrst && b_out_valid && b_out_ready) begin
            if (b_exp_q.size() == 0) check("b_unexpected_out", 64'(b_exp_q.size()), 64'd1);
            else check("b_blk_out", 64'(b_blk_out), 64'(b_exp_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    // All tasks start and end at posedge+1.
    task automatic a_load_key(input logic [127:0] k, input string tag);
        int n, lat;
        a_key = k;
        a_key_valid = 1'b1;
        n = 0;
        @(negedge ck);
        while (!a_key_ready && n < 100) begin @(negedge ck); n++; end
        @(posedge ck); #1;
        a_key_valid = 1'b0;
        check({tag, "_kl_low"}, 64'(a_key_loaded), 64'd0);
        check({tag, "_kr_low"}, 64'(a_key_ready), 64'd0);
        lat = 0;
        while (!a_key_loaded && lat < 200) begin @(posedge ck); #1; lat++; end
        check({tag, "_key_lat"}, 64'(lat), 64'd40);
    endtask

    task automatic a_offer(input logic [63:0] blk, input logic mode, input logic [63:0] exp);
        int n;
        a_blk_in = blk;
        a_enc_dec = mode;
        a_in_valid = 1'b1;
        a_exp_q.push_back(exp);
        n = 0;
        @(negedge ck);
        while (!a_in_ready && n < 100) begin @(negedge ck); n++; end
        @(posedge ck); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic a_wait_out(input string tag);
        int lat;
        lat = 0;
        while (!a_out_valid && lat < 300) begin @(posedge ck); #1; lat++; end
        check({tag, "_lat"}, 64'(lat), 64'd44);
        if (a_out_ready) begin
            @(posedge ck); #1;
            check({tag, "_ov_drop"}, 64'(a_out_valid), 64'd0);
            check({tag, "_ir_back"}, 64'(a_in_ready), 64'd1);
        end
    endtask

    task automatic b_run(input logic [31:0] blk, input logic mode, input logic [31:0] exp, input string tag);
        int lat;
        b_blk_in = blk;
        b_enc_dec = mode;
        b_in_valid = 1'b1;
        b_exp_q.push_back(exp);
        @(negedge ck);
        check({tag, "_in_ready"}, 64'(b_in_ready), 64'd1);
        @(posedge ck); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 300) begin @(posedge ck); #1; lat++; end
        check({tag, "_lat"}, 64'(lat), 64'd32);
        @(posedge ck); #1;
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge ck);
        #1;
        check("rst_key_ready", 64'(a_key_ready), 64'd1);
        check("rst_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_key_loaded", 64'(a_key_loaded), 64'd0);
        check("rst_blk_out", a_blk_out, 64'd0);
        nrst = 1'b1;
        @(posedge ck); #1;

        // Basic encrypt then decrypt with the reference key.
        a_load_key(KEY, "k1");
        a_offer(PT, 1'b1, CT);
        a_wait_out("enc1");
        a_offer(CT, 1'b0, PT);
        a_wait_out("dec1");

        // Backpressure: result held while out_ready is low.
        a_out_ready = 1'b0;
        a_offer(PT, 1'b1, CT);
        a_wait_out("bp");
        for (int i = 0; i < 20; i++) begin
            @(negedge ck);
            check("bp_blk_stable", a_blk_out, CT);
            check("bp_in_ready", 64'(a_in_ready), 64'd0);
            check("bp_key_ready", 64'(a_key_ready), 64'd0);
            check("bp_out_valid", 64'(a_out_valid), 64'd1);
        end
        @(posedge ck); #1;
        a_out_ready = 1'b1;
        @(posedge ck); #1;
        check("bp_ov_drop", 64'(a_out_valid), 64'd0);
        check("bp_ir_back", 64'(a_in_ready), 64'd1);

        // Reset during round 10 discards the block and invalidates the key.
        a_offer(PT, 1'b1, CT);
        repeat (10) @(posedge ck);
        #1;
        nrst = 1'b0;
        @(posedge ck); #1;
        check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst_key_loaded", 64'(a_key_loaded), 64'd0);
        check("mid_rst_in_ready", 64'(a_in_ready), 64'd0);
        check("mid_rst_key_ready", 64'(a_key_ready), 64'd1);
        a_exp_q.delete();
        b_exp_q.delete();
        nrst = 1'b1;
        a_blk_in = PT;
        a_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ck);
            check("nokey_in_ready", 64'(a_in_ready), 64'd0);
        end
        @(posedge ck); #1;
        a_in_valid = 1'b0;

        // Rekey: an all-zero key, then the reference key must fully overwrite the store.
        a_load_key(128'd0, "kz");
        a_load_key(KEY, "k2");
        a_offer(PT, 1'b1, CT);
        a_wait_out("rekey");

        // Key and block offered together in IDLE: block wins, key ignored.
        a_key = 128'd0;
        a_key_valid = 1'b1;
        a_blk_in = PT;
        a_enc_dec = 1'b1;
        a_in_valid = 1'b1;
        a_exp_q.push_back(CT);
        @(posedge ck); #1;
        a_key_valid = 1'b0;
        a_in_valid = 1'b0;
        check("both_key_ready", 64'(a_key_ready), 64'd0);
        check("both_in_ready", 64'(a_in_ready), 64'd0);
        check("both_key_loaded", 64'(a_key_loaded), 64'd1);
        a_wait_out("both");

        // Simon32/64 instance.
        b_key = B_KEY;
        b_key_valid = 1'b1;
        @(negedge ck);
        check("b_key_ready", 64'(b_key_ready), 64'd1);
        @(posedge ck); #1;
        b_key_valid = 1'b0;
        lat = 0;
        while (!b_key_loaded && lat < 200) begin @(posedge ck); #1; lat++; end
        check("b_key_lat", 64'(lat), 64'd28);
        b_run(B_PT, 1'b1, B_CT, "b_enc");
        b_run(B_CT, 1'b0, B_PT, "b_dec");

        repeat (2) @(posedge ck);
        #1;
        check("a_sb_empty", 64'(a_exp_q.size()), 64'd0);
        check("b_sb_empty", 64'(b_exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
